// File: rtl/fpchk_pkg.sv
// Shared types and helpers for the floating-point result checker.
// Holds the checker state encoding and a width-generic NaN detector.
package fpchk_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFail = 2'd2
    } fpchk_state_e;

    // Word is right-aligned in 64 bits; exponent sits just below the sign bit.
    function automatic logic is_nan(input logic [63:0] w, input int width, input int exp_w);
        logic exp_ones;
        logic frac_nz;
        exp_ones = 1'b1;
        frac_nz  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i < width - 1 && i >= width - 1 - exp_w) begin
                exp_ones = exp_ones & w[i];
            end else if (i < width - 1 - exp_w) begin
                frac_nz = frac_nz | w[i];
            end
        end
        return exp_ones && frac_nz;
    endfunction

endpackage

// File: rtl/fpchk_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with occupancy output and synchronous clear.
// Callers must qualify push_i with not-full and pop_i with not-empty.
module fpchk_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CntW-1:0]  count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + 1'b1;
            if (pop_i)  rptr_d = rptr_q + 1'b1;
            if (push_i && !pop_i) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!push_i && pop_i) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !clr_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fp_result_checker.sv
// Scoreboard comparing DUT results against queued expected words, with counters and
// first-failure capture. Define FPCHK_NAN_EQUIV_EN to treat any two NaNs as equal.
module fp_result_checker
    import fpchk_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned EXP_W = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 32,
    localparam int unsigned PendW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             exp_valid_i,
    output logic             exp_ready_o,
    input  logic [WIDTH-1:0] exp_data_i,
    input  logic             act_valid_i,
    input  logic [WIDTH-1:0] act_data_i,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic [CNT_W-1:0] orphan_cnt_o,
    output logic [PendW-1:0] pending_o,
    output logic             ff_valid_o,
    output logic [WIDTH-1:0] ff_exp_o,
    output logic [WIDTH-1:0] ff_act_o,
    output logic [CNT_W-1:0] ff_index_o,
    output logic [1:0]       state_o
);

    localparam logic [PendW-1:0] DepthCnt = PendW'(DEPTH);

    logic [WIDTH-1:0] head;
    logic [PendW-1:0] pending;
    logic             push, pop, orphan, match, mismatch, nan_eq;

    logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d, orph_q, orph_d, ffi_q, ffi_d;
    logic             ffv_q, ffv_d;
    logic [WIDTH-1:0] ffe_q, ffe_d, ffa_q, ffa_d;
    fpchk_state_e     state_q, state_d;

    fpchk_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (exp_data_i),
        .rdata_o (head),
        .count_o (pending)
    );

    // Ready depends on occupancy only, so a full FIFO refuses a push even while popping.
    assign exp_ready_o = pending < DepthCnt;
    assign push        = exp_valid_i && exp_ready_o && !clr_i;
    assign pop         = act_valid_i && (pending != '0) && !clr_i;
    assign orphan      = act_valid_i && (pending == '0) && !clr_i;

`ifdef FPCHK_NAN_EQUIV_EN
    assign nan_eq = is_nan(64'(head), int'(WIDTH), int'(EXP_W)) &&
                    is_nan(64'(act_data_i), int'(WIDTH), int'(EXP_W));
`else
    assign nan_eq = 1'b0;
`endif

    assign match    = (head == act_data_i) || nan_eq;
    assign mismatch = pop && !match;

    always_comb begin
        pass_d  = pass_q;
        fail_d  = fail_q;
        orph_d  = orph_q;
        ffv_d   = ffv_q;
        ffe_d   = ffe_q;
        ffa_d   = ffa_q;
        ffi_d   = ffi_q;
        state_d = state_q;
        if (clr_i) begin
            pass_d  = '0;
            fail_d  = '0;
            orph_d  = '0;
            ffv_d   = 1'b0;
            ffe_d   = '0;
            ffa_d   = '0;
            ffi_d   = '0;
            state_d = StIdle;
        end else begin
            if (pop && match && pass_q != '1) pass_d = pass_q + 1'b1;
            if (mismatch && fail_q != '1)     fail_d = fail_q + 1'b1;
            if (orphan && orph_q != '1)       orph_d = orph_q + 1'b1;
            // Index is the count of results seen before this one.
            if (mismatch && !ffv_q) begin
                ffv_d = 1'b1;
                ffe_d = head;
                ffa_d = act_data_i;
                ffi_d = pass_q + fail_q;
            end
            if (mismatch || orphan) begin
                state_d = StFail;
            end else if (push && state_q == StIdle) begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pass_q  <= '0;
            fail_q  <= '0;
            orph_q  <= '0;
            ffv_q   <= 1'b0;
            ffe_q   <= '0;
            ffa_q   <= '0;
            ffi_q   <= '0;
            state_q <= StIdle;
        end else begin
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            orph_q  <= orph_d;
            ffv_q   <= ffv_d;
            ffe_q   <= ffe_d;
            ffa_q   <= ffa_d;
            ffi_q   <= ffi_d;
            state_q <= state_d;
        end
    end

    assign pass_cnt_o   = pass_q;
    assign fail_cnt_o   = fail_q;
    assign orphan_cnt_o = orph_q;
    assign pending_o    = pending;
    assign ff_valid_o   = ffv_q;
    assign ff_exp_o     = ffe_q;
    assign ff_act_o     = ffa_q;
    assign ff_index_o   = ffi_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_fp_result_checker.sv
// Bench for fp_result_checker: directed scenarios then random traffic against a
// queue-based reference model; small CNT_W so counter saturation is reached.
module tb_fp_result_checker;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int ST_IDLE = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_FAIL = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr, exp_valid, exp_ready, act_valid;
    logic [31:0] exp_data, act_data;
    logic [CNT_W-1:0] pass_cnt, fail_cnt, orphan_cnt, ff_index;
    logic [2:0]  pending;
    logic        ff_valid;
    logic [31:0] ff_exp, ff_act;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_q [$];
    int          m_pass, m_fail, m_orph, m_ffi, m_state;
    bit          m_ffv;
    logic [31:0] m_ffe, m_ffa;

    fp_result_checker #(
        .WIDTH (32),
        .EXP_W (8),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clr_i        (clr),
        .exp_valid_i  (exp_valid),
        .exp_ready_o  (exp_ready),
        .exp_data_i   (exp_data),
        .act_valid_i  (act_valid),
        .act_data_i   (act_data),
        .pass_cnt_o   (pass_cnt),
        .fail_cnt_o   (fail_cnt),
        .orphan_cnt_o (orphan_cnt),
        .pending_o    (pending),
        .ff_valid_o   (ff_valid),
        .ff_exp_o     (ff_exp),
        .ff_act_o     (ff_act),
        .ff_index_o   (ff_index),
        .state_o      (state)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

`ifdef FPCHK_NAN_EQUIV_EN
    function automatic bit nan32(input logic [31:0] w);
        return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
    endfunction
`endif

    function automatic bit fp_equal(input logic [31:0] a, input logic [31:0] b);
`ifdef FPCHK_NAN_EQUIV_EN
        if (nan32(a) && nan32(b)) return 1'b1;
`endif
        return a == b;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pass = 0; m_fail = 0; m_orph = 0; m_ffi = 0;
        m_ffv = 1'b0; m_ffe = '0; m_ffa = '0; m_state = ST_IDLE;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pass"},     64'(pass_cnt),   64'(m_pass));
        check({tag, ".fail"},     64'(fail_cnt),   64'(m_fail));
        check({tag, ".orphan"},   64'(orphan_cnt), 64'(m_orph));
        check({tag, ".pending"},  64'(pending),    64'(m_q.size()));
        check({tag, ".ff_valid"}, 64'(ff_valid),   64'(m_ffv));
        check({tag, ".ff_exp"},   64'(ff_exp),     64'(m_ffe));
        check({tag, ".ff_act"},   64'(ff_act),     64'(m_ffa));
        check({tag, ".ff_index"}, 64'(ff_index),   64'(m_ffi));
        check({tag, ".state"},    64'(state),      64'(m_state));
    endtask

    // One clock of stimulus; the model advances by the same rules the edge applies.
    task automatic step(input logic ev, input logic [31:0] ed, input logic av,
                        input logic [31:0] ad, input logic cl, input string tag);
        bit          can_push;
        logic [31:0] head;
        @(negedge clk);
        exp_valid = ev; exp_data = ed; act_valid = av; act_data = ad; clr = cl;
        #1;
        check({tag, ".exp_ready"}, 64'(exp_ready), 64'(m_q.size() < DEPTH));
        if (cl) begin
            model_reset();
        end else begin
            can_push = ev && (m_q.size() < DEPTH);
            if (av && m_q.size() > 0) begin
                head = m_q.pop_front();
                if (fp_equal(head, ad)) begin
                    if (m_pass < CNT_MAX) m_pass++;
                end else begin
                    if (!m_ffv) begin
                        m_ffv = 1'b1; m_ffe = head; m_ffa = ad;
                        m_ffi = (m_pass + m_fail) % (CNT_MAX + 1);
                    end
                    if (m_fail < CNT_MAX) m_fail++;
                    m_state = ST_FAIL;
                end
            end else if (av) begin
                if (m_orph < CNT_MAX) m_orph++;
                m_state = ST_FAIL;
            end
            if (can_push) begin
                m_q.push_back(ed);
                if (m_state == ST_IDLE) m_state = ST_RUN;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
        exp_valid = 1'b0; act_valid = 1'b0; clr = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input string tag);
        step(1'b1, d, 1'b0, 32'd0, 1'b0, tag);
    endtask

    task automatic act(input logic [31:0] d, input string tag);
        step(1'b0, 32'd0, 1'b1, d, 1'b0, tag);
    endtask

    task automatic do_clr(input string tag);
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, tag);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) == 0) w = (w & 32'h807F_FFFF) | 32'h7F80_0001;
        return w;
    endfunction

    initial begin
        logic        ev, av, cl;
        logic [31:0] ed, ad;

        rst_n = 1'b0; clr = 1'b0; exp_valid = 1'b0; act_valid = 1'b0;
        exp_data = '0; act_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset.exp_ready", 64'(exp_ready), 64'd1);
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Two matching results.
        push(32'h3F80_0000, "m1"); push(32'h4000_0000, "m2");
        act(32'h3F80_0000, "m3");  act(32'h4000_0000, "m4");
        check("match.pass", 64'(pass_cnt), 64'd2);
        check("match.fail", 64'(fail_cnt), 64'd0);
        check("match.state", 64'(state), 64'(ST_RUN));
        check("match.pending", 64'(pending), 64'd0);

        // Second result mismatches.
        do_clr("c1");
        push(32'h3F80_0000, "f1"); push(32'h4040_0000, "f2");
        act(32'h3F80_0000, "f3");  act(32'h4040_0001, "f4");
        check("mism.fail", 64'(fail_cnt), 64'd1);
        check("mism.ff_exp", 64'(ff_exp), 64'h4040_0000);
        check("mism.ff_act", 64'(ff_act), 64'h4040_0001);
        check("mism.ff_index", 64'(ff_index), 64'd1);
        check("mism.state", 64'(state), 64'(ST_FAIL));

        // Push at full is refused even with a same-cycle pop.
        do_clr("c2");
        for (int i = 0; i < DEPTH; i++) push(32'h1000_0000 + 32'(i), "full");
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 32'h1000_0000, 1'b0, "fullpop");
        check("full.pending", 64'(pending), 64'(DEPTH - 1));
        check("full.pass", 64'(pass_cnt), 64'd1);

        // Orphan with a same-cycle push: no bypass, no capture.
        do_clr("c3");
        step(1'b1, 32'h3F80_0000, 1'b1, 32'h3F80_0000, 1'b0, "orph");
        check("orph.count", 64'(orphan_cnt), 64'd1);
        check("orph.pending", 64'(pending), 64'd1);
        check("orph.ff_valid", 64'(ff_valid), 64'd0);
        check("orph.state", 64'(state), 64'(ST_FAIL));

        // Two NaNs with different payloads.
        do_clr("c4");
        push(32'h7FC0_0000, "nan1");
        act(32'h7FC0_0001, "nan2");
`ifdef FPCHK_NAN_EQUIV_EN
        check("nan.pass", 64'(pass_cnt), 64'd1);
`else
        check("nan.fail", 64'(fail_cnt), 64'd1);
`endif

        // Clear wins over a mismatching compare.
        do_clr("c5");
        for (int i = 0; i < 3; i++) push(32'h2000_0000 + 32'(i), "cp");
        step(1'b1, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, "clrmis");
        check("clr.fail", 64'(fail_cnt), 64'd0);
        check("clr.pending", 64'(pending), 64'd0);
        check("clr.state", 64'(state), 64'(ST_IDLE));
        check("clr.ff_valid", 64'(ff_valid), 64'd0);

        // Asynchronous reset in the middle of a cycle discards FIFO contents.
        push(32'h5555_0000, "r1"); push(32'h5555_0001, "r2");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst.pending", 64'(pending), 64'd0);
        check("arst.exp_ready", 64'(exp_ready), 64'd1);
        check_all("arst");
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic, mostly matching results, occasional clears.
        for (int n = 0; n < 500; n++) begin
            ev = ($urandom_range(0, 9) < 6);
            ed = rand_word();
            av = ($urandom_range(0, 9) < 5);
            if (m_q.size() > 0 && $urandom_range(0, 3) != 0) ad = m_q[0];
            else ad = rand_word();
            cl = ($urandom_range(0, 79) == 0);
            step(ev, ed, av, ad, cl, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
